seven_seg_scan_ctrl: RTL and testbench
======================================

SEVEN_SEG_SCAN_CTRL -- requirements
Module: seven_seg_scan_ctrl

Interface
REQ-001 SHALL provide parameter CLK_DIV, default 100000, clock cycles each digit is driven (minimum 4).
REQ-002 SHALL provide parameter BLANK_CYC, default 16, dead-time cycles with all anodes off between digits (1 to CLK_DIV-1).
REQ-003 SHALL provide port clk, input, 1, the block's one clock, rising-edge.
REQ-004 SHALL provide port rst, input, 1, reset, asynchronous and active-high.
REQ-005 SHALL provide port enable, input, 1, scanning on when high; display dark when low.
REQ-006 SHALL provide port load_data, input, 16, four hex digits; [3:0] is digit 0 (rightmost).
REQ-007 SHALL provide port load_valid, input, 1, load_data is offered.
REQ-008 SHALL provide port load_ready, output, 1, the pending buffer can accept.
REQ-009 SHALL provide port seg, output, 7, segments {a,b,c,d,e,f,g}, a is MSB, active-low.
REQ-010 SHALL provide port an, output, 4, digit anodes, active-low, an[i] drives digit i.
REQ-011 SHALL provide port frame_start, output, 1, one-cycle pulse when digit 0 begins driving.

Function
REQ-012 SHALL implement states OFF, BLANK, DRIVE and a 2-bit digit index idx.
REQ-013 OFF: an=1111, seg=1111111; when enable=1, go to BLANK with idx=0 and the counter cleared.
REQ-014 BLANK: an=1111, seg=1111111 for BLANK_CYC cycles, then go to DRIVE.
REQ-015 DRIVE: an has only bit idx low, seg=decode(nibble idx of disp_reg) for CLK_DIV cycles; then idx=idx+1 mod 4 (3 wraps to 0) and go to BLANK.
REQ-016 Outputs SHALL be registered, changing one cycle after the state/idx change that causes them.
REQ-017 Decode SHALL be active-low: 0->0000001, 1->1001111, 2->0010010, 3->0000110, 4->1001100, 5->0100100, 6->0100000, 7->0001111.
REQ-018 Decode continued: 8->0000000, 9->0000100, A->0000010, b->1100000, C->0110001, d->1000010, E->0010000, F->0111000.
REQ-019 A handshake SHALL transfer when load_valid and load_ready are both high on a clock edge; load_data goes to the pending register and pend_full is set.
REQ-020 load_ready SHALL equal the inverse of pend_full, with no combinational path from load_valid.
REQ-021 Frame boundary is the BLANK->DRIVE transition with idx=0: if pend_full, copy pending to disp_reg, clear pend_full and pulse frame_start on the same edge. Values never change in mid-frame.
REQ-022 In OFF, a full pending register SHALL copy to disp_reg on the next cycle.
REQ-023 Handshake and boundary in the same cycle with pend_full=0: new data stays pending until the next boundary.
REQ-024 enable falling in any state: next state OFF, idx=0, counter cleared; disp_reg and pending are kept.

Reset
REQ-025 rst high SHALL immediately force: state OFF, an=1111, seg=1111111, frame_start=0, idx=0, counter=0, disp_reg=0000h, pend_full=0 (load_ready=1).
REQ-026 rst asserted mid-frame SHALL discard any pending data; after release, scanning starts only under REQ-013.

Configuration
REQ-027 Macro LEADING_ZERO_BLANK_EN defined: in DRIVE, digits above the most-significant nonzero nibble keep an=1111, seg=1111111 for their slot; digit 0 is always shown; slot timing is unchanged.
REQ-028 Macro LEADING_ZERO_BLANK_EN undefined: all four digits are always driven.

Structure
REQ-029 Package seg7_pkg SHALL hold the state enum, the 16-entry active-low segment constant table, and the constants SEG_OFF=7'b1111111 and AN_OFF=4'b1111.
REQ-030 Decoding SHALL be a purely combinational sub-module hex_seg_decode (4-bit in, 7-bit out), instantiated once.

Verification (CLK_DIV=8, BLANK_CYC=2)
REQ-031 Reset, then enable=1 with disp_reg=0 -> an cycles 1110,1101,1011,0111; each is low for 8 cycles with 2 all-off cycles between; seg=0000001.
REQ-032 Load 1234h mid-frame -> load_ready=0 the next cycle; display unchanged until frame_start; digit0 seg=1001100, digit3 seg=1001111.
REQ-033 Offer a second load while pend_full=1 -> no transfer; it is accepted the cycle after the boundary clears pend_full.
REQ-034 Drop enable during digit 2 -> next cycle an=1111; re-enable -> digit 0 follows after 2 blank cycles.
REQ-035 rst pulse during DRIVE with data pending -> an=1111 immediately; after release, disp_reg=0 and load_ready=1.
REQ-036 LEADING_ZERO_BLANK_EN defined, data 0005h -> only an[0] goes low, seg=0100100; data 0000h -> digit 0 shows 0000001.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared types and constants for the four-digit seven-segment scan controller.
// Segment bits are {a,b,c,d,e,f,g} with a as MSB; every output here is active-low.
package seg7_pkg;

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_BLANK = 2'd1,
    ST_DRIVE = 2'd2
  } scan_state_t;

  localparam logic [6:0] SEG_OFF = 7'b1111111;
  localparam logic [3:0] AN_OFF  = 4'b1111;

  localparam logic [6:0] SEG_TABLE [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0000010, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0010000, 7'b0111000
  };

  function automatic logic [3:0] an_select(input logic [1:0] idx);
    return ~(4'b0001 << idx);
  endfunction

endpackage

// File: rtl/hex_seg_decode.sv
// Combinational hex nibble to active-low seven-segment pattern.
module hex_seg_decode
  import seg7_pkg::*;
(
  input  logic [3:0] i_hex,
  output logic [6:0] o_seg
);

  assign o_seg = SEG_TABLE[i_hex];

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Four-digit multiplexed seven-segment scanner with a one-deep load buffer and
// frame-aligned display updates. Define LEADING_ZERO_BLANK_EN to darken leading zeros.
module seven_seg_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int unsigned CLK_DIV   = 100000,
  parameter int unsigned BLANK_CYC = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [15:0] load_data,
  input  logic        load_valid,
  output logic        load_ready,
  output logic [6:0]  seg,
  output logic [3:0]  an,
  output logic        frame_start
);

  localparam int unsigned CNT_W = $clog2(CLK_DIV);
  localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);

  scan_state_t      r_state;
  logic [1:0]       r_idx;
  logic [CNT_W-1:0] r_cnt;
  logic [15:0]      r_disp;
  logic [15:0]      r_pend;
  logic             r_pend_full;
  logic [3:0]       r_an;
  logic [6:0]       r_seg;
  logic             r_frame_start;

  logic [3:0]       w_nibble;
  logic [6:0]       w_seg;
  logic             w_show;
  logic             w_boundary;
  logic             w_copy;
  logic             w_xfer;

  assign load_ready  = ~r_pend_full;
  assign an          = r_an;
  assign seg         = r_seg;
  assign frame_start = r_frame_start;

  assign w_xfer     = load_valid & ~r_pend_full;
  assign w_boundary = enable && (r_state == ST_BLANK) && (r_cnt == BLANK_LAST) && (r_idx == 2'd0);
  assign w_copy     = r_pend_full && (w_boundary || (r_state == ST_OFF));

  always_comb begin
    w_nibble = r_disp[3:0];
    case (r_idx)
      2'd1:    w_nibble = r_disp[7:4];
      2'd2:    w_nibble = r_disp[11:8];
      2'd3:    w_nibble = r_disp[15:12];
      default: w_nibble = r_disp[3:0];
    endcase
  end

  always_comb begin
    w_show = 1'b1;
`ifdef LEADING_ZERO_BLANK_EN
    // A digit is lit if it or any more-significant digit is nonzero; digit 0 always lit.
    case (r_idx)
      2'd1:    w_show = |r_disp[15:4];
      2'd2:    w_show = |r_disp[15:8];
      2'd3:    w_show = |r_disp[15:12];
      default: w_show = 1'b1;
    endcase
`else
    w_show = 1'b1;
`endif
  end

  hex_seg_decode u_dec (
    .i_hex (w_nibble),
    .o_seg (w_seg)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_OFF;
      r_idx   <= '0;
      r_cnt   <= '0;
    end else if (!enable) begin
      r_state <= ST_OFF;
      r_idx   <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_OFF: begin
          r_state <= ST_BLANK;
          r_idx   <= '0;
          r_cnt   <= '0;
        end
        ST_BLANK: begin
          if (r_cnt == BLANK_LAST) begin
            r_state <= ST_DRIVE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_DRIVE: begin
          if (r_cnt == DRIVE_LAST) begin
            r_state <= ST_BLANK;
            r_idx   <= r_idx + 1'b1;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= ST_OFF;
          r_idx   <= '0;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  // Accept and copy are exclusive: an accept needs pend_full low, a copy needs it high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_disp      <= '0;
      r_pend      <= '0;
      r_pend_full <= 1'b0;
    end else begin
      if (w_xfer) begin
        r_pend      <= load_data;
        r_pend_full <= 1'b1;
      end else if (w_copy) begin
        r_disp      <= r_pend;
        r_pend_full <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_an          <= AN_OFF;
      r_seg         <= SEG_OFF;
      r_frame_start <= 1'b0;
    end else begin
      r_frame_start <= w_boundary;
      if ((r_state == ST_DRIVE) && w_show) begin
        r_an  <= an_select(r_idx);
        r_seg <= w_seg;
      end else begin
        r_an  <= AN_OFF;
        r_seg <= SEG_OFF;
      end
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Scoreboard bench: expected digit runs are queued as loads/enables are driven and
// popped by a monitor that compresses an/seg into runs with their preceding dark gap.
module tb_seven_seg_scan_ctrl;

  localparam int unsigned CLK_DIV   = 8;
  localparam int unsigned BLANK_CYC = 2;
  localparam int unsigned SLOT      = CLK_DIV + BLANK_CYC;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [15:0] load_data;
  logic        load_valid;
  logic        load_ready;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        frame_start;

  int unsigned checks = 0;
  int unsigned errors = 0;

  typedef struct {
    logic [3:0]  an;
    logic [6:0]  seg;
    int unsigned len;
    int unsigned gap;
  } exp_t;

  exp_t q[$];
  int unsigned last_shown = 4;

  seven_seg_scan_ctrl #(.CLK_DIV(CLK_DIV), .BLANK_CYC(BLANK_CYC)) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .load_data   (load_data),
    .load_valid  (load_valid),
    .load_ready  (load_ready),
    .seg         (seg),
    .an          (an),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] seg_of(input logic [3:0] h);
    case (h)
      4'h0: return 7'b0000001;  4'h1: return 7'b1001111;
      4'h2: return 7'b0010010;  4'h3: return 7'b0000110;
      4'h4: return 7'b1001100;  4'h5: return 7'b0100100;
      4'h6: return 7'b0100000;  4'h7: return 7'b0001111;
      4'h8: return 7'b0000000;  4'h9: return 7'b0000100;
      4'hA: return 7'b0000010;  4'hB: return 7'b1100000;
      4'hC: return 7'b0110001;  4'hD: return 7'b1000010;
      4'hE: return 7'b0010000;  default: return 7'b0111000;
    endcase
  endfunction

  function automatic int unsigned shown_of(input logic [15:0] d);
`ifdef LEADING_ZERO_BLANK_EN
    if (d[15:12] != 4'h0) return 4;
    if (d[11:8] != 4'h0) return 3;
    if (d[7:4] != 4'h0) return 2;
    return 1;
`else
    return 4;
`endif
  endfunction

  task automatic push_entry(input int unsigned idx, input logic [15:0] d,
                            input int unsigned len, input int unsigned gap);
    exp_t e;
    logic [3:0] one;
    one   = 4'b0001;
    e.an  = ~(one << idx);
    e.seg = seg_of(d[idx*4 +: 4]);
    e.len = len;
    e.gap = gap;
    q.push_back(e);
  endtask

  // cont=1: frame follows the previous one without a pause; its first gap includes dark slots.
  task automatic push_frame(input logic [15:0] d, input bit cont);
    int unsigned sh;
    int unsigned g;
    sh = shown_of(d);
    for (int unsigned i = 0; i < sh; i++) begin
      if (i == 0) g = cont ? (BLANK_CYC + (4 - last_shown) * SLOT) : 0;
      else        g = BLANK_CYC;
      push_entry(i, d, CLK_DIV, g);
    end
    last_shown = sh;
  endtask

  logic [10:0] run_val = '0;
  int unsigned run_len = 0;
  int unsigned run_gap = 0;
  int unsigned gap_cnt = 0;
  logic        prev_fs = 1'b0;

  task automatic finish_run();
    exp_t e;
    check("digit_run_expected", 32'(q.size() != 0), 32'd1);
    if (q.size() != 0) begin
      e = q.pop_front();
      check("run_an", 32'(run_val[10:7]), 32'(e.an));
      check("run_seg", 32'(run_val[6:0]), 32'(e.seg));
      if (e.len != 0) check("run_len", run_len, e.len);
      if (e.gap != 0) check("run_gap", run_gap, e.gap);
    end
  endtask

  always @(negedge clk) begin
    if (prev_fs) begin
      check("fs_one_cycle", 32'(frame_start), 32'd0);
      check("fs_then_digit0", 32'(an), 32'(4'b1110));
    end
    prev_fs = frame_start;
    if (an == 4'hF) begin
      check("dark_seg", 32'(seg), 32'(7'h7F));
      if (run_len != 0) finish_run();
      run_len = 0;
      gap_cnt++;
    end else begin
      if ((run_len != 0) && ({an, seg} != run_val)) begin
        finish_run();
        run_len = 0;
      end
      if (run_len == 0) begin
        run_val = {an, seg};
        run_gap = gap_cnt;
      end
      run_len++;
      gap_cnt = 0;
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic step_n(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) step();
  endtask

  // Caller has just raised enable (or released rst with enable high) at a step point.
  task automatic enable_latency(input string tag);
    int unsigned n;
    n = 0;
    do begin
      step();
      n++;
    end while ((an == 4'hF) && (n < 20));
    check({tag, "_latency"}, n, 32'd4);
    check({tag, "_first_an"}, 32'(an), 32'(4'b1110));
  endtask

  task automatic wait_drain(input string tag);
    int unsigned n;
    n = 0;
    while ((q.size() != 0) && (n < 400)) begin
      step();
      n++;
    end
    check(tag, 32'(q.size()), 32'd0);
  endtask

  task automatic off_load(input logic [15:0] d);
    load_data  = d;
    load_valid = 1'b1;
    step();
    load_valid = 1'b0;
    check("off_load_taken", 32'(load_ready), 32'd0);
    step();
    check("off_copy_frees_pending", 32'(load_ready), 32'd1);
  endtask

  initial begin
    int unsigned n;
    rst        = 1'b1;
    enable     = 1'b0;
    load_valid = 1'b0;
    load_data  = '0;
    step_n(3);
    check("rst_an", 32'(an), 32'hF);
    check("rst_seg", 32'(seg), 32'h7F);
    check("rst_fs", 32'(frame_start), 32'd0);
    check("rst_ready", 32'(load_ready), 32'd1);
    rst = 1'b0;
    step_n(2);
    check("off_dark", 32'(an), 32'hF);

    push_frame(16'h0000, 1'b0);
    enable = 1'b1;
    enable_latency("start");

    load_data  = 16'h1234;
    load_valid = 1'b1;
    step();
    check("ready_low_after_load", 32'(load_ready), 32'd0);
    push_frame(16'h1234, 1'b1);
    load_data = 16'hABCD;
    n = 0;
    while ((load_ready == 1'b0) && (n < 100)) begin
      step();
      n++;
    end
    check("second_load_ready", 32'(load_ready), 32'd1);
    check("ready_at_boundary", 32'(frame_start), 32'd1);
    push_frame(16'hABCD, 1'b1);
    step();
    check("ready_low_after_second", 32'(load_ready), 32'd0);
    load_valid = 1'b0;

    push_entry(0, 16'hABCD, CLK_DIV, BLANK_CYC);
    push_entry(1, 16'hABCD, CLK_DIV, BLANK_CYC);
    push_entry(2, 16'hABCD, 0, BLANK_CYC);
    n = 0;
    while (!((q.size() == 1) && (an == 4'b1011)) && (n < 200)) begin
      step();
      n++;
    end
    check("reach_digit2", 32'(an), 32'(4'b1011));
    enable = 1'b0;
    step_n(2);
    check("dark_after_disable", 32'(an), 32'hF);
    step_n(5);
    check("stays_dark", 32'(an), 32'hF);

    push_entry(0, 16'hABCD, CLK_DIV, 0);
    push_entry(1, 16'hABCD, 0, BLANK_CYC);
    last_shown = 4;
    enable = 1'b1;
    enable_latency("reenable");
    load_data  = 16'h5555;
    load_valid = 1'b1;
    step();
    load_valid = 1'b0;
    check("ready_low_pending", 32'(load_ready), 32'd0);
    n = 0;
    while ((an != 4'b1101) && (n < 100)) begin
      step();
      n++;
    end
    check("reach_digit1", 32'(an), 32'(4'b1101));
    step_n(2);
    #2 rst = 1'b1;
    #1;
    check("async_rst_an", 32'(an), 32'hF);
    check("async_rst_seg", 32'(seg), 32'h7F);
    check("async_rst_fs", 32'(frame_start), 32'd0);
    check("async_rst_ready", 32'(load_ready), 32'd1);
    step_n(2);
    rst = 1'b0;
    check("ready_after_reset", 32'(load_ready), 32'd1);
    push_frame(16'h0000, 1'b0);
    push_frame(16'h0000, 1'b1);
    enable_latency("after_reset");
    wait_drain("drain_zero_frames");
    enable = 1'b0;

    step_n(3);
    off_load(16'h9876);
    push_frame(16'h9876, 1'b0);
    enable = 1'b1;
    enable_latency("show_9876");
    wait_drain("drain_9876");
    enable = 1'b0;

`ifdef LEADING_ZERO_BLANK_EN
    step_n(3);
    off_load(16'h0005);
    push_frame(16'h0005, 1'b0);
    push_frame(16'h0005, 1'b1);
    enable = 1'b1;
    enable_latency("lzb_0005");
    wait_drain("drain_0005");
    enable = 1'b0;
    step_n(3);
    off_load(16'h0000);
    push_frame(16'h0000, 1'b0);
    enable = 1'b1;
    enable_latency("lzb_0000");
    wait_drain("drain_0000");
    enable = 1'b0;
`endif

    step_n(4);
    check("final_dark", 32'(an), 32'hF);
    check("queue_empty_end", 32'(q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
